branch_resolve_bht: RTL and testbench

- Next-generation branch unit for the RV32 core; replaces the purely combinational next-PC branch block.
- Resolves conditional branches, JAL and JALR in EX, and registers the result behind a valid/ready handshake.
- Holds a parametrised bimodal branch history table (BHT) of 2-bit counters. Fetch reads it through a lookup port; EX trains it on resolve.
- Reports mispredicts to the PC/flush logic.

---
 rtl/branch_resolve_bht_if.sv | 35 +++
 rtl/branch_resolve_bht.sv | 159 +++++++++++++++
 tb/tb_branch_resolve_bht.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_bht_if.sv
// EX-stage request/result bundle for branch_resolve_bht.
// master = EX pipeline side, slave = the branch unit.
interface branch_resolve_bht_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsdata_a;
  logic [XLEN-1:0] rsdata_b;
  logic [XLEN-1:0] imm;
  logic [2:0]      ctrl;
  logic            br_en;
  logic            jump_en;
  logic            jalr_en;
  logic            pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_next_pc;
  logic [XLEN-1:0] out_link;
  logic            out_taken;
  logic            out_mispredict;

  modport master (
    output in_valid, pc, rsdata_a, rsdata_b, imm, ctrl,
           br_en, jump_en, jalr_en, pred_taken, out_ready,
    input  in_ready, out_valid, out_next_pc, out_link, out_taken, out_mispredict
  );

  modport slave (
    input  in_valid, pc, rsdata_a, rsdata_b, imm, ctrl,
           br_en, jump_en, jalr_en, pred_taken, out_ready,
    output in_ready, out_valid, out_next_pc, out_link, out_taken, out_mispredict
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch/JAL/JALR resolver with registered valid/ready output and a bimodal BHT.
// Define BRANCH_STATS_EN to build the branch and mispredict counters.
module branch_resolve_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] BHT_INIT    = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       lookup_pc,
  output logic                  lookup_taken,
  input  logic                  flush,
  branch_resolve_bht_if.slave   bus,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]      bht_reg [BHT_ENTRIES];
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lk_idx;
  logic [1:0]      bht_cur;
  logic [1:0]      bht_next;

  logic            out_valid_reg;
  logic [XLEN-1:0] out_next_pc_reg;
  logic [XLEN-1:0] out_link_reg;
  logic            out_taken_reg;
  logic            out_mispredict_reg;

  logic            accept;
  logic            cond_true;
  logic            cond_legal;
  logic            train;
  logic [XLEN-1:0] link_calc;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] next_calc;
  logic            taken_calc;
  logic            mis_calc;

  // Only the index bits of lookup_pc select a counter.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  assign bus.in_ready = !flush && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign upd_idx      = bus.pc[IDX_W+1:2];
  assign lk_idx       = lookup_pc[IDX_W+1:2];
  assign lookup_taken = bht_reg[lk_idx][1];

  assign link_calc   = bus.pc + XLEN'(4);
  assign rel_target  = bus.pc + bus.imm;
  assign jalr_target = (bus.rsdata_a + bus.imm) & ~XLEN'(1);

  always_comb begin
    cond_true  = 1'b0;
    cond_legal = 1'b1;
    case (bus.ctrl)
      3'b000:  cond_true = (bus.rsdata_a == bus.rsdata_b);
      3'b001:  cond_true = (bus.rsdata_a != bus.rsdata_b);
      3'b100:  cond_true = ($signed(bus.rsdata_a) <  $signed(bus.rsdata_b));
      3'b101:  cond_true = ($signed(bus.rsdata_a) >= $signed(bus.rsdata_b));
      3'b110:  cond_true = (bus.rsdata_a <  bus.rsdata_b);
      3'b111:  cond_true = (bus.rsdata_a >= bus.rsdata_b);
      default: cond_legal = 1'b0;
    endcase
  end

  // Decode priority is JALR over JAL over conditional branch.
  always_comb begin
    next_calc  = link_calc;
    taken_calc = 1'b0;
    mis_calc   = bus.pred_taken;
    train      = 1'b0;
    if (bus.jalr_en) begin
      next_calc  = jalr_target;
      taken_calc = 1'b1;
      mis_calc   = 1'b1;
    end else if (bus.jump_en) begin
      next_calc  = rel_target;
      taken_calc = 1'b1;
      mis_calc   = !bus.pred_taken;
    end else if (bus.br_en) begin
      next_calc  = cond_true ? rel_target : link_calc;
      taken_calc = cond_true;
      mis_calc   = (cond_true != bus.pred_taken);
      train      = cond_legal;
    end
  end

  assign bht_cur = bht_reg[upd_idx];

  always_comb begin
    bht_next = bht_cur;
    if (taken_calc) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= BHT_INIT;
    end else if (accept && train) begin
      bht_reg[upd_idx] <= bht_next;
    end
  end

  // accept already excludes flush, so a flushed operation never lands here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg      <= 1'b0;
      out_next_pc_reg    <= '0;
      out_link_reg       <= '0;
      out_taken_reg      <= 1'b0;
      out_mispredict_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg      <= 1'b1;
      out_next_pc_reg    <= next_calc;
      out_link_reg       <= link_calc;
      out_taken_reg      <= taken_calc;
      out_mispredict_reg <= mis_calc;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid      = out_valid_reg;
  assign bus.out_next_pc    = out_next_pc_reg;
  assign bus.out_link       = out_link_reg;
  assign bus.out_taken      = out_taken_reg;
  assign bus.out_mispredict = out_mispredict_reg;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (accept && train)    stat_branches_reg    <= stat_branches_reg + 32'd1;
      if (accept && mis_calc) stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht: vector table plus scoreboard,
// with hand sequences for BHT saturation, backpressure, flush and async reset.
module tb_branch_resolve_bht;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        lookup_taken;
  logic        flush = 1'b0;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_bht_if #(.XLEN(32)) bus ();

  branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(16), .BHT_INIT(2'b01)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .lookup_taken     (lookup_taken),
    .flush            (flush),
    .bus              (bus),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  typedef struct {
    logic [31:0] pc, a, b, imm;
    logic [2:0]  ctrl;
    logic        br, jp, jr, pred;
    logic [31:0] nxt, lnk;
    logic        tk, mis, lb;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[18];
  vec_t mon_e;
  logic [31:0] exp_br  = '0;
  logic [31:0] exp_mis = '0;

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                              logic [2:0] ctrl, logic br, logic jp, logic jr, logic pred,
                              logic [31:0] nxt, logic [31:0] lnk, logic tk, logic mis, logic lb);
    vec_t v;
    v.pc = pc; v.a = a; v.b = b; v.imm = imm; v.ctrl = ctrl;
    v.br = br; v.jp = jp; v.jr = jr; v.pred = pred;
    v.nxt = nxt; v.lnk = lnk; v.tk = tk; v.mis = mis; v.lb = lb;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(vec_t v);
    sb.push_back(v);
`ifdef BRANCH_STATS_EN
    if (v.lb)  exp_br  = exp_br + 32'd1;
    if (v.mis) exp_mis = exp_mis + 32'd1;
`endif
  endtask

  task automatic drive_v(vec_t v);
    bus.pc = v.pc; bus.rsdata_a = v.a; bus.rsdata_b = v.b; bus.imm = v.imm;
    bus.ctrl = v.ctrl; bus.br_en = v.br; bus.jump_en = v.jp; bus.jalr_en = v.jr;
    bus.pred_taken = v.pred;
  endtask

  // Optionally checks lookup_taken in the accept cycle: it must still show the old counter.
  task automatic send(vec_t v, logic chk_old, logic exp_old);
    bit got = 0;
    drive_v(v);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    if (chk_old) chk("lookup_no_bypass", 32'(lookup_taken), 32'(exp_old));
    push(v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_lookup(logic [31:0] p, logic e, string name);
    lookup_pc = p;
    #1;
    chk(name, 32'(lookup_taken), 32'(e));
  endtask

  task automatic check_stats(string tag);
    chk({tag, "_stat_branches"}, stat_branches, exp_br);
    chk({tag, "_stat_mispredicts"}, stat_mispredicts, exp_mis);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_queue_size", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("[TB] FAIL sb_underflow: got out_next_pc %h with no expected entry", bus.out_next_pc);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] txn pc=%h next=%h link=%h taken=%b mis=%b", mon_e.pc,
                 bus.out_next_pc, bus.out_link, bus.out_taken, bus.out_mispredict);
        chk("next_pc", bus.out_next_pc, mon_e.nxt);
        chk("link", bus.out_link, mon_e.lnk);
        chk("taken", 32'(bus.out_taken), 32'(mon_e.tk));
        chk("mispredict", 32'(bus.out_mispredict), 32'(mon_e.mis));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t va, vb, vt, vn;
    tbl[0]  = mk(32'h0,    32'h4,    32'hFFFFFFFF, 32'h8, 3'b000, 1,0,0,0, 32'h4,    32'h4,   0,0,1);
    tbl[1]  = mk(32'h0,    32'h4,    32'hFFFFFFFF, 32'h8, 3'b001, 1,0,0,0, 32'h8,    32'h4,   1,1,1);
    tbl[2]  = mk(32'h0,    32'h4,    32'hFFFFFFFF, 32'h8, 3'b100, 1,0,0,0, 32'h4,    32'h4,   0,0,1);
    tbl[3]  = mk(32'h0,    32'h4,    32'hFFFFFFFF, 32'h8, 3'b101, 1,0,0,0, 32'h8,    32'h4,   1,1,1);
    tbl[4]  = mk(32'h0,    32'h4,    32'hFFFFFFFF, 32'h8, 3'b110, 1,0,0,0, 32'h8,    32'h4,   1,1,1);
    tbl[5]  = mk(32'h0,    32'h4,    32'hFFFFFFFF, 32'h8, 3'b111, 1,0,0,0, 32'h4,    32'h4,   0,0,1);
    tbl[6]  = mk(32'h0,    32'h4,    32'hFFFFFFFF, 32'h8, 3'b010, 1,0,0,0, 32'h4,    32'h4,   0,0,0);
    tbl[7]  = mk(32'h100,  32'h1001, 32'h0, 32'h4,        3'b000, 0,0,1,0, 32'h1004, 32'h104, 1,1,0);
    tbl[8]  = mk(32'hFFFFFFFC, 32'h0, 32'h0, 32'h8,       3'b000, 0,1,0,0, 32'h4,    32'h0,   1,1,0);
    tbl[9]  = mk(32'h200,  32'h0,    32'h0, 32'hFFFFFFF0, 3'b000, 0,1,0,1, 32'h1F0,  32'h204, 1,0,0);
    tbl[10] = mk(32'h300,  32'h0,    32'h0, 32'h40,       3'b000, 0,0,0,1, 32'h304,  32'h304, 0,1,0);
    tbl[11] = mk(32'h400,  32'h2000, 32'h0, 32'h11,       3'b000, 1,1,1,0, 32'h2010, 32'h404, 1,1,0);
    tbl[12] = mk(32'h500,  32'h1,    32'h2, 32'h20,       3'b000, 1,1,0,1, 32'h520,  32'h504, 1,0,0);
    tbl[13] = mk(32'h600,  32'h5,    32'h5, 32'hFFFFFF00, 3'b000, 1,0,0,1, 32'h500,  32'h604, 1,0,1);
    tbl[14] = mk(32'h700,  32'hFFFFFFFF, 32'h0, 32'h40,   3'b110, 1,0,0,1, 32'h704,  32'h704, 0,1,1);
    tbl[15] = mk(32'h10,   32'h7,    32'h7, 32'hC,        3'b001, 1,0,0,0, 32'h14,   32'h14,  0,0,1);
    tbl[16] = mk(32'h800,  32'h0,    32'h1, 32'h8,        3'b001, 0,0,0,0, 32'h804,  32'h804, 0,0,0);
    tbl[17] = mk(32'h900,  32'hFFFFFFFF, 32'h0, 32'h2,    3'b000, 0,0,1,1, 32'h0,    32'h904, 1,1,0);

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive_v(tbl[0]);

    // Reset state
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_next_pc", bus.out_next_pc, 32'd0);
    chk("rst_link", bus.out_link, 32'd0);
    chk("rst_taken", 32'(bus.out_taken), 32'd0);
    chk("rst_mispredict", 32'(bus.out_mispredict), 32'd0);
    check_lookup(32'h40, 1'b0, "rst_lookup");
    check_stats("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Saturation at pc 0x40: 01 -> 10 -> 11 -> 11, then down to 00
    vt = mk(32'h40, 32'h1, 32'h1, 32'h10, 3'b000, 1,0,0,0, 32'h50, 32'h44, 1,1,1);
    vn = mk(32'h40, 32'h1, 32'h1, 32'h10, 3'b001, 1,0,0,1, 32'h44, 32'h44, 0,1,1);
    lookup_pc = 32'h40;
    send(vt, 1'b1, 1'b0); check_lookup(32'h40, 1'b1, "sat_t1");
    send(vt, 1'b0, 1'b0); check_lookup(32'h40, 1'b1, "sat_t2");
    send(vt, 1'b0, 1'b0); check_lookup(32'h40, 1'b1, "sat_t3");
    send(vn, 1'b1, 1'b1); check_lookup(32'h40, 1'b1, "sat_n1");
    send(vn, 1'b0, 1'b0); check_lookup(32'h40, 1'b0, "sat_n2");
    send(vn, 1'b0, 1'b0); check_lookup(32'h40, 1'b0, "sat_n3");
    send(vn, 1'b0, 1'b0); check_lookup(32'h40, 1'b0, "sat_n4");
    drain();

    // Vector table, back to back
    for (int i = 0; i < 18; i++) send(tbl[i], 1'b0, 1'b0);
    drain();
    check_stats("table");

    // Illegal condition leaves the counter alone (index of pc 0x20)
    send(mk(32'h20, 32'h0, 32'h0, 32'h8, 3'b000, 1,0,0,1, 32'h28, 32'h24, 1,0,1), 1'b0, 1'b0);
    check_lookup(32'h20, 1'b1, "ill_pre");
    send(mk(32'h20, 32'h0, 32'h0, 32'h8, 3'b011, 1,0,0,0, 32'h24, 32'h24, 0,0,0), 1'b0, 1'b0);
    check_lookup(32'h20, 1'b1, "ill_unchanged");
    send(mk(32'h20, 32'hFFFFFFFF, 32'h0, 32'h8, 3'b101, 1,0,0,0, 32'h24, 32'h24, 0,0,1), 1'b0, 1'b0);
    check_lookup(32'h20, 1'b0, "ill_post");
    drain();

    // Backpressure: hold for three cycles
    va = mk(32'hB00, 32'h0, 32'h0, 32'h100, 3'b000, 0,1,0,0, 32'hC00, 32'hB04, 1,1,0);
    vb = mk(32'hB10, 32'h0, 32'h0, 32'h0,   3'b000, 0,0,0,0, 32'hB14, 32'hB14, 0,0,0);
    bus.out_ready = 1'b0;
    drive_v(va); bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept_a", 32'(bus.in_ready), 32'd1);
    push(va);
    @(posedge clk); #1;
    drive_v(vb);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_next_pc", bus.out_next_pc, 32'hC00);
      chk("bp_link", bus.out_link, 32'hB04);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_b", 32'(bus.in_ready), 32'd1);
    push(vb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    // Flush while a result is held and a branch is offered
    bus.out_ready = 1'b0;
    send(mk(32'hC00, 32'h0, 32'h0, 32'h4, 3'b000, 0,1,0,1, 32'hC04, 32'hC04, 1,0,0), 1'b0, 1'b0);
    drive_v(mk(32'h2C, 32'h3, 32'h3, 32'h10, 3'b000, 1,0,0,0, 32'h3C, 32'h30, 1,1,1));
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    void'(sb.pop_front());
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check_lookup(32'h2C, 1'b0, "flush_bht");
    check_stats("flush");
    @(posedge clk); #1;

    // Train pc 0x30 to strongly taken, then reset between edges with a held result
    vt = mk(32'h30, 32'h9, 32'h9, 32'h4, 3'b000, 1,0,0,1, 32'h34, 32'h34, 1,0,1);
    send(vt, 1'b0, 1'b0);
    send(vt, 1'b0, 1'b0);
    drain();
    check_lookup(32'h30, 1'b1, "pre_rst_lookup");
    check_stats("pre_rst");
    bus.out_ready = 1'b0;
    send(mk(32'hA00, 32'h0, 32'h0, 32'h0, 3'b000, 0,1,0,0, 32'hA00, 32'hA04, 1,1,0), 1'b0, 1'b0);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_next_pc", bus.out_next_pc, 32'd0);
    chk("arst_link", bus.out_link, 32'd0);
    chk("arst_taken", 32'(bus.out_taken), 32'd0);
    chk("arst_mispredict", 32'(bus.out_mispredict), 32'd0);
    for (int i = 0; i < 16; i++) check_lookup(32'(i * 4), 1'b0, "arst_lookup");
    sb.delete();
    exp_br = '0; exp_mis = '0;
    check_stats("arst");
    bus.out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
